// File: rtl/rng_hist_binner_pkg.sv
// Shared types and defaults for the rng_hist_binner histogram stage.
package hist_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_BIN_BITS = 3;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_LIMIT_W  = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  function automatic int num_bins(input int bin_bits);
    return 1 << bin_bits;
  endfunction
endpackage

// File: rtl/rng_hist_binner_if.sv
// Sample stream (valid/ready) and one-cycle read port of the histogram binner.
interface rng_hist_binner_if
  import hist_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BIN_BITS = DEF_BIN_BITS,
  parameter int CNT_W    = DEF_CNT_W
) ();
  logic                s_valid;
  logic [DATA_W-1:0]   s_data;
  logic                s_ready;
  logic                rd_en;
  logic [BIN_BITS-1:0] rd_idx;
  logic [CNT_W-1:0]    rd_data;
  logic                rd_valid;

  modport master (output s_valid, s_data, rd_en, rd_idx,
                  input  s_ready, rd_data, rd_valid);
  modport slave  (input  s_valid, s_data, rd_en, rd_idx,
                  output s_ready, rd_data, rd_valid);
endinterface

// File: rtl/rng_hist_binner_bin_counter.sv
// One histogram bin counter. HIST_SATURATE_EN selects saturate (else wrap);
// ovf_pulse flags the increment that saturates-and-drops or wraps.
module hist_bin_counter
  import hist_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf_pulse
);
  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full    = &r_count;
  assign ovf_pulse = inc && !clr && w_full;
  assign count     = r_count;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      r_count <= '0;
    else if (clr)    r_count <= '0;
    else if (inc) begin
`ifdef HIST_SATURATE_EN
      if (!w_full) r_count <= r_count + 1'b1;
`else
      r_count <= r_count + 1'b1;
`endif
    end
  end
endmodule

// File: rtl/rng_hist_binner.sv
// Histogram of LFSR samples binned by MSBs, with sample limit and read port.
// Bin counter behaviour at full scale is selected by HIST_SATURATE_EN.
module rng_hist_binner
  import hist_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BIN_BITS = DEF_BIN_BITS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LIMIT_W  = DEF_LIMIT_W
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic [LIMIT_W-1:0] sample_limit,
  rng_hist_binner_if.slave   s,
  output logic [LIMIT_W-1:0] total,
  output logic               busy,
  output logic               done,
  output logic               ovf
);
  localparam int NUM_BINS = num_bins(BIN_BITS);

  state_e                         r_state, w_state_nxt;
  logic [LIMIT_W-1:0]             r_limit, r_total, w_total_inc;
  logic                           w_acc, w_hit, w_load;
  logic [BIN_BITS-1:0]            w_bin;
  logic [NUM_BINS-1:0]            w_inc, w_ovf;
  logic [NUM_BINS-1:0][CNT_W-1:0] w_count;
  logic [CNT_W-1:0]               r_rd_data;
  logic                           r_rd_valid, r_ovf;
  logic                           w_unused;

  // Only the top BIN_BITS of a sample matter.
  assign w_unused    = ^s.s_data[DATA_W-BIN_BITS-1:0];
  assign w_bin       = s.s_data[DATA_W-1 -: BIN_BITS];
  assign w_acc       = s.s_valid && (r_state == RUN) && !clear;
  assign w_total_inc = (&r_total) ? r_total : r_total + 1'b1;
  assign w_hit       = w_acc && (r_limit != '0) && (w_total_inc == r_limit);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start && !stop) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
        RUN: begin
          if (stop)       w_state_nxt = IDLE;
          else if (w_hit) w_state_nxt = DONE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= IDLE;
      r_limit    <= '0;
      r_total    <= '0;
      r_ovf      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= s.rd_en;
      if (w_load) r_limit <= sample_limit;
      if (clear)      r_total <= '0;
      else if (w_acc) r_total <= w_total_inc;
      if (clear)           r_ovf <= 1'b0;
      else if (|w_ovf)     r_ovf <= 1'b1;
      // Counter outputs are pre-update, so a colliding read sees the old count.
      if (s.rd_en) r_rd_data <= w_count[s.rd_idx];
    end
  end

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
    assign w_inc[g] = w_acc && (w_bin == BIN_BITS'(g));
    hist_bin_counter #(.CNT_W(CNT_W)) u_cnt (
      .aclk      (aclk),
      .areset    (areset),
      .inc       (w_inc[g]),
      .clr       (clear),
      .count     (w_count[g]),
      .ovf_pulse (w_ovf[g])
    );
  end

  assign s.s_ready  = (r_state == RUN);
  assign s.rd_data  = r_rd_data;
  assign s.rd_valid = r_rd_valid;
  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign total      = r_total;
  assign ovf        = r_ovf;
endmodule

// File: tb/tb_rng_hist_binner.sv
// Directed bench: main instance (CNT_W=16) plus a narrow one (CNT_W=4) for overflow.
module tb_rng_hist_binner;
  logic        aclk = 1'b0;
  logic        areset;
  logic        start, stop, clear;
  logic [15:0] sample_limit;
  logic [15:0] total0, total1;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  int          checks = 0;
  int          failures = 0;

  rng_hist_binner_if #(.DATA_W(32), .BIN_BITS(3), .CNT_W(16)) if0 ();
  rng_hist_binner_if #(.DATA_W(32), .BIN_BITS(3), .CNT_W(4))  if1 ();

  rng_hist_binner #(.DATA_W(32), .BIN_BITS(3), .CNT_W(16), .LIMIT_W(16)) u0 (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop), .clear(clear),
    .sample_limit(sample_limit), .s(if0), .total(total0), .busy(busy0),
    .done(done0), .ovf(ovf0));

  rng_hist_binner #(.DATA_W(32), .BIN_BITS(3), .CNT_W(4), .LIMIT_W(16)) u1 (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop), .clear(clear),
    .sample_limit(sample_limit), .s(if1), .total(total1), .busy(busy1),
    .done(done1), .ovf(ovf1));

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [31:0] d, input int n);
    if0.s_valid = 1'b1;
    if0.s_data  = d;
    repeat (n) tick();
    if0.s_valid = 1'b0;
  endtask

  task automatic rd0(input logic [2:0] idx, input logic [15:0] exp, input string tag);
    if0.rd_en  = 1'b1;
    if0.rd_idx = idx;
    tick();
    if0.rd_en  = 1'b0;
    chk({tag, "_vld"}, 32'(if0.rd_valid), 32'd1);
    chk(tag, 32'(if0.rd_data), 32'(exp));
  endtask

  task automatic pulse_start(input logic [15:0] lim);
    sample_limit = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [31:0] vec [4];
  logic [3:0]  exp_small;

  initial begin
    areset = 1'b1; start = 0; stop = 0; clear = 0; sample_limit = '0;
    if0.s_valid = 0; if0.s_data = '0; if0.rd_en = 0; if0.rd_idx = '0;
    if1.s_valid = 0; if1.s_data = '0; if1.rd_en = 0; if1.rd_idx = '0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_ready", 32'(if0.s_ready), 0);
    chk("rst_total", 32'(total0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_rdv", 32'(if0.rd_valid), 0);
    areset = 1'b0;
    tick();

    // limit 4, four back-to-back samples
    vec[0] = 32'h0000_0000; vec[1] = 32'h2000_0000;
    vec[2] = 32'hE000_0000; vec[3] = 32'hE000_0001;
    pulse_start(16'd4);
    chk("t1_busy", 32'(busy0), 1);
    chk("t1_ready", 32'(if0.s_ready), 1);
    if0.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if0.s_data = vec[i];
      tick();
      if (i < 3) chk("t1_ready_run", 32'(if0.s_ready), 1);
    end
    if0.s_valid = 1'b0;
    chk("t1_done", 32'(done0), 1);
    chk("t1_ready_done", 32'(if0.s_ready), 0);
    chk("t1_total", 32'(total0), 4);
    send0(32'hE000_0000, 3);
    chk("t1_done_ignore", 32'(total0), 4);
    rd0(3'd0, 16'd1, "t1_bin0");
    rd0(3'd1, 16'd1, "t1_bin1");
    rd0(3'd7, 16'd2, "t1_bin7");
    rd0(3'd2, 16'd0, "t1_bin2");
    tick();
    chk("t1_rdv_fall", 32'(if0.rd_valid), 0);

    // unlimited, 300 into bin 5, stop, ignored samples, resume
    pulse_clear();
    chk("t2_clr_total", 32'(total0), 0);
    pulse_start(16'd0);
    send0(32'hA000_0000, 300);
    chk("t2_total300", 32'(total0), 300);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_idle", 32'(busy0), 0);
    send0(32'hA000_0000, 5);
    chk("t2_idle_ignore", 32'(total0), 300);
    pulse_start(16'd0);
    chk("t2_busy", 32'(busy0), 1);
    send0(32'hA000_0000, 1);
    rd0(3'd5, 16'd301, "t2_bin5");
    chk("t2_total", 32'(total0), 301);

    // read collides with increment of bin 3
    pulse_clear();
    pulse_start(16'd0);
    send0(32'h6000_0000, 6);
    if0.s_valid = 1'b1; if0.s_data = 32'h6000_0000;
    if0.rd_en = 1'b1; if0.rd_idx = 3'd3;
    tick();
    if0.s_valid = 1'b0; if0.rd_en = 1'b0;
    chk("t3_coll_vld", 32'(if0.rd_valid), 1);
    chk("t3_coll_data", 32'(if0.rd_data), 6);
    rd0(3'd3, 16'd7, "t3_after");

    // narrow counter overflow
    pulse_clear();
    pulse_start(16'd0);
    if1.s_valid = 1'b1; if1.s_data = 32'h4000_0000;
    repeat (15) tick();
    if1.s_valid = 1'b0;
    chk("t4_ovf_at15", 32'(ovf1), 0);
    if1.s_valid = 1'b1;
    repeat (2) tick();
    if1.s_valid = 1'b0;
`ifdef HIST_SATURATE_EN
    exp_small = 4'd15;
`else
    exp_small = 4'd1;
`endif
    if1.rd_en = 1'b1; if1.rd_idx = 3'd2;
    tick();
    if1.rd_en = 1'b0;
    chk("t4_count", 32'(if1.rd_data), 32'(exp_small));
    chk("t4_ovf", 32'(ovf1), 1);
    chk("t4_total", 32'(total1), 17);
    chk("t4_main_ovf", 32'(ovf0), 0);

    // clear beats start and a sample while in DONE
    pulse_clear();
    pulse_start(16'd2);
    send0(32'h2000_0000, 2);
    chk("t5_done", 32'(done0), 1);
    clear = 1'b1; start = 1'b1; sample_limit = 16'd0;
    if0.s_valid = 1'b1; if0.s_data = 32'h2000_0000;
    tick();
    clear = 1'b0; start = 1'b0; if0.s_valid = 1'b0;
    chk("t5_done_clr", 32'(done0), 0);
    chk("t5_busy_clr", 32'(busy0), 0);
    chk("t5_total", 32'(total0), 0);
    chk("t5_ovf_small", 32'(ovf1), 0);
    rd0(3'd1, 16'd0, "t5_bin1");
    chk("t5_still_idle", 32'(busy0), 0);

    // async reset mid-RUN
    pulse_start(16'd0);
    send0(32'h8000_0000, 10);
    chk("t6_total10", 32'(total0), 10);
    areset = 1'b1;
    #1;
    chk("t6_rst_total", 32'(total0), 0);
    chk("t6_rst_busy", 32'(busy0), 0);
    chk("t6_rst_ready", 32'(if0.s_ready), 0);
    chk("t6_rst_rddata", 32'(if0.rd_data), 0);
    chk("t6_rst_bin4", 32'(u0.w_count[4]), 0);
    tick();
    areset = 1'b0;
    tick();
    pulse_start(16'd0);
    send0(32'h8000_0000, 1);
    chk("t6_total1", 32'(total0), 1);
    rd0(3'd4, 16'd1, "t6_bin4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rng_hist_binner.md
# rng_hist_binner

Histogram stage directly downstream of the LFSR random-number generator. It accepts generated samples over a valid/ready stream and sorts each one into one of 2^BIN_BITS bins by the sample's most-significant bits. It keeps a per-bin count and a total count, stops automatically after a programmable number of samples, and exposes counts through a one-cycle-latency read port that the AXI-Lite register file maps into its address space.

## Interface
Parameters:
- DATA_W, 32, sample width.
- BIN_BITS, 3, log2 of the bin count (8 bins by default).
- CNT_W, 16, per-bin counter width.
- LIMIT_W, 16, width of the sample limit and the total counter.

Ports:
- aclk  in  1  clock. One clock; reset is asynchronous and active-high.
- areset  in  1  asynchronous active-high reset.
- start  in  1  pulse; begin or resume accumulation.
- stop  in  1  pulse; halt accumulation.
- clear  in  1  pulse; zero all counts and flags.
- sample_limit  in  LIMIT_W  number of samples to accept before DONE; 0 means unlimited. Sampled on the start cycle.
- s_valid  in  1  sample valid from the LFSR.
- s_data  in  DATA_W  sample value.
- s_ready  out  1  block can accept a sample.
- rd_en  in  1  read request.
- rd_idx  in  BIN_BITS  bin to read.
- rd_data  out  CNT_W  bin count.
- rd_valid  out  1  rd_data is valid.
- total  out  LIMIT_W  samples accepted since the last clear.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- ovf  out  1  sticky flag: a bin counter overflowed.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start goes to RUN and latches sample_limit into limit_q.
  - If start and stop are both asserted in the same cycle, stop wins and the state stays IDLE.
- RUN:
  - s_ready = 1.
  - A sample is accepted when s_valid && s_ready.
  - Accepted sample: bin = s_data[DATA_W-1 -: BIN_BITS]; that bin's counter increments and total increments.
  - When limit_q != 0 and the acceptance makes total == limit_q, go to DONE. That last sample is counted.
  - stop goes to IDLE. A sample accepted in the same cycle as stop is still counted.
- DONE:
  - s_ready = 0.
  - start goes to RUN and latches a new limit. Counts are not cleared, so the new limit is compared against the running total.
- clear, from any state:
  - Zeroes all bins, total and ovf, and goes to IDLE.
  - clear has priority over start, stop and a sample in the same cycle; that sample is dropped.
- total saturates at all-ones in every build.
- Read port:
  - rd_en registers rd_idx; rd_data and rd_valid appear on the next cycle.
  - rd_valid is high for one cycle per rd_en.
  - A read of a bin that is incrementing in the same cycle returns the pre-increment value.
- Outputs with s_ready = 0 (IDLE, DONE) ignore s_valid; no samples are buffered.

## Timing
- Reset values: s_ready, rd_data, rd_valid, total, busy, done and ovf are 0; all bins are 0; limit_q is 0.
- Count latency: a sample accepted at edge N is visible in the bin and in total after edge N.
- A read issued at edge N+1 returns the updated value at edge N+2.
- s_ready, busy and done are registered-state decodes. s_ready falls in the cycle after the limit-reaching acceptance.
- Throughput: one sample per cycle in RUN.
- Reset asserted mid-RUN returns the block to IDLE immediately with all counts zero.

## Configuration
- HIST_SATURATE_EN defined:
  - Bin counters saturate at 2^CNT_W-1.
  - An increment that is dropped at saturation sets ovf.
- HIST_SATURATE_EN undefined:
  - Bin counters wrap to 0.
  - The wrap sets ovf.
- ovf is sticky until clear or reset in both builds.

## Structure
- Package hist_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the NUM_BINS = 2**BIN_BITS helper;
  - default width constants.
- Sub-module hist_bin_counter:
  - one counter per bin, instantiated in a generate loop;
  - ports: inc, clr, count, ovf_pulse;
  - implements the HIST_SATURATE_EN behaviour locally.
- The top level holds the FSM, total/limit logic, the bin decode and the read mux register.

## Test plan
- Reset, start with limit 4, then samples 0x00000000, 0x20000000, 0xE0000000, 0xE0000001 back-to-back:
  - bins 0, 1 and 7 read 1, 1 and 2; total = 4; done = 1; s_ready = 0 from the cycle after the 4th sample.
- Start with limit 0 and 300 samples into bin 5; stop; start again and send 1 sample:
  - bin 5 = 301; busy = 1 after the second start; samples sent while in IDLE are ignored.
- Read bin 3 in the same cycle that bin 3 increments from 6 to 7:
  - rd_data = 6 next cycle; a read on the following cycle returns 7.
- CNT_W = 4 with 17 samples to bin 2:
  - with HIST_SATURATE_EN, count = 15 and ovf = 1;
  - without it, count = 1 and ovf = 1.
- clear asserted together with start and s_valid while in DONE:
  - state IDLE; all bins, total and ovf are 0; the sample is dropped.
- areset asserted mid-RUN after 10 samples:
  - all outputs and bins are 0 immediately; start afterwards resumes counting from 0.
